// File: rtl/alu_status_unit.sv
// ALU status unit: captures ALU results and S/Z/C/V flags, feeds the stored carry back
// to the ALU, evaluates branch condition codes and keeps a small flag stack for
// interrupt entry/exit.
module alu_status_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    input  logic [WIDTH-1:0] ALU_result,
    input  logic             S,
    input  logic             Z,
    input  logic             C,
    input  logic             V,
    input  logic [3:0]       flag_we,
    input  logic             z_chain,
    input  logic             cond_eval,
    input  logic [3:0]       cond,
    input  logic             push,
    input  logic             pop,
    output logic             C_in,
    output logic [3:0]       flags,
    output logic [WIDTH-1:0] result_q,
    output logic             result_valid,
    output logic             cond_true,
    output logic             cond_valid,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             stack_err
);

    localparam int unsigned SpW  = $clog2(DEPTH) + 1;
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SpW-1:0] SpFull = SpW'(DEPTH);

    typedef enum logic [3:0] {
        CcAl, CcEq, CcNe, CcCs, CcCc, CcMi, CcPl, CcVs,
        CcVc, CcHi, CcLs, CcGe, CcLt, CcGt, CcLe, CcNv
    } cond_e;

    // Flag vector layout is {S, Z, C, V}.
    logic [3:0]       flags_q, flags_d, alu_flags;
    logic [3:0]       stack_q [DEPTH];
    logic [SpW-1:0]   sp_q, sp_d;
    logic [IdxW-1:0]  top_idx, wr_idx;
    logic             stack_we;
    logic             err_d, err_q;
    logic             empty_q, full_q;
    logic [WIDTH-1:0] result_r;
    logic             rvalid_q, ctrue_q, cvalid_q, cond_hit;
    logic             sp_zero, sp_full;

    assign sp_zero = (sp_q == '0);
    assign sp_full = (sp_q == SpFull);
    assign top_idx = IdxW'(sp_q - SpW'(1));

    // Masked ALU flag merge; z_chain ANDs the new Z into the stored one.
    always_comb begin
        alu_flags = flags_q;
        if (flag_we[3]) alu_flags[3] = S;
        if (flag_we[2]) alu_flags[2] = z_chain ? (flags_q[2] & Z) : Z;
        if (flag_we[1]) alu_flags[1] = C;
        if (flag_we[0]) alu_flags[0] = V;
    end

    // Flag / stack-pointer next state; pop outranks an ALU capture on the flags.
    always_comb begin
        flags_d  = flags_q;
        sp_d     = sp_q;
        err_d    = err_q;
        stack_we = 1'b0;
        wr_idx   = IdxW'(sp_q);
        if (push && pop) begin
            stack_we = 1'b1;
            if (sp_zero) begin
                // Nothing to replace: acts as a plain push, so a capture still lands.
                sp_d = SpW'(1);
                if (alu_valid) flags_d = alu_flags;
            end else begin
                // Replace the top entry; stored flags are left as they are.
                wr_idx = top_idx;
            end
        end else if (pop) begin
            if (sp_zero) begin
                err_d = 1'b1;
            end else begin
                flags_d = stack_q[top_idx];
                sp_d    = sp_q - SpW'(1);
            end
        end else begin
            if (push) begin
                if (sp_full) begin
                    err_d = 1'b1;
                end else begin
                    stack_we = 1'b1;
                    sp_d     = sp_q + SpW'(1);
                end
            end
            if (alu_valid) flags_d = alu_flags;
        end
    end

    // Condition code evaluation against the currently stored flags.
    always_comb begin
        cond_hit = 1'b0;
        unique case (cond_e'(cond))
            CcAl: cond_hit = 1'b1;
            CcEq: cond_hit = flags_q[2];
            CcNe: cond_hit = !flags_q[2];
            CcCs: cond_hit = flags_q[1];
            CcCc: cond_hit = !flags_q[1];
            CcMi: cond_hit = flags_q[3];
            CcPl: cond_hit = !flags_q[3];
            CcVs: cond_hit = flags_q[0];
            CcVc: cond_hit = !flags_q[0];
            CcHi: cond_hit = flags_q[1] && !flags_q[2];
            CcLs: cond_hit = !flags_q[1] || flags_q[2];
            CcGe: cond_hit = (flags_q[3] == flags_q[0]);
            CcLt: cond_hit = (flags_q[3] != flags_q[0]);
            CcGt: cond_hit = !flags_q[2] && (flags_q[3] == flags_q[0]);
            CcLe: cond_hit = flags_q[2] || (flags_q[3] != flags_q[0]);
            CcNv: cond_hit = 1'b0;
            default: cond_hit = 1'b0;
        endcase
    end

    // Status, result and condition registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q  <= '0;
            sp_q     <= '0;
            err_q    <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            result_r <= '0;
            rvalid_q <= 1'b0;
            ctrue_q  <= 1'b0;
            cvalid_q <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            sp_q     <= sp_d;
            err_q    <= err_d;
            empty_q  <= (sp_d == '0);
            full_q   <= (sp_d == SpFull);
            rvalid_q <= alu_valid;
            cvalid_q <= cond_eval;
            if (alu_valid) result_r <= ALU_result;
            if (cond_eval) ctrue_q <= cond_hit;
        end
    end

    // Stack storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (!reset && stack_we) stack_q[wr_idx] <= flags_q;
    end

    assign C_in         = flags_q[1];
    assign flags        = flags_q;
    assign result_q     = result_r;
    assign result_valid = rvalid_q;
    assign cond_true    = ctrue_q;
    assign cond_valid   = cvalid_q;
    assign stack_empty  = empty_q;
    assign stack_full   = full_q;
    assign stack_err    = err_q;

endmodule

// File: tb/tb_alu_status_unit.sv
// Self-checking bench for alu_status_unit: directed scenarios plus randomized traffic,
// all compared against a queue-based behavioural model.
module tb_alu_status_unit;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             alu_valid;
    logic [WIDTH-1:0] ALU_result;
    logic             S, Z, C, V;
    logic [3:0]       flag_we;
    logic             z_chain, cond_eval;
    logic [3:0]       cond;
    logic             push, pop;
    logic             C_in;
    logic [3:0]       flags;
    logic [WIDTH-1:0] result_q;
    logic             result_valid, cond_true, cond_valid;
    logic             stack_empty, stack_full, stack_err;

    alu_status_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .ALU_result   (ALU_result),
        .S            (S),
        .Z            (Z),
        .C            (C),
        .V            (V),
        .flag_we      (flag_we),
        .z_chain      (z_chain),
        .cond_eval    (cond_eval),
        .cond         (cond),
        .push         (push),
        .pop          (pop),
        .C_in         (C_in),
        .flags        (flags),
        .result_q     (result_q),
        .result_valid (result_valid),
        .cond_true    (cond_true),
        .cond_valid   (cond_valid),
        .stack_empty  (stack_empty),
        .stack_full   (stack_full),
        .stack_err    (stack_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [3:0]       m_flags;
    logic [WIDTH-1:0] m_result;
    logic             m_rvalid, m_ctrue, m_cvalid, m_err;
    logic [3:0]       m_stack[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Branch condition table, evaluated with plain booleans on {S,Z,C,V}.
    function automatic logic cond_ref(input logic [3:0] f, input logic [3:0] cc);
        logic s, z, c, v;
        s = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc)
            4'd0:  return 1'b1;
            4'd1:  return z;
            4'd2:  return !z;
            4'd3:  return c;
            4'd4:  return !c;
            4'd5:  return s;
            4'd6:  return !s;
            4'd7:  return v;
            4'd8:  return !v;
            4'd9:  return c && !z;
            4'd10: return !c || z;
            4'd11: return s == v;
            4'd12: return s != v;
            4'd13: return !z && (s == v);
            4'd14: return z || (s != v);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        logic [3:0] nf;
        logic [3:0] inb;
        if (reset) begin
            m_flags = '0; m_result = '0; m_rvalid = 0; m_ctrue = 0; m_cvalid = 0; m_err = 0;
            m_stack.delete();
            return;
        end
        inb = {S, Z, C, V};
        nf  = m_flags;
        for (int i = 0; i < 4; i++) if (flag_we[i]) nf[i] = inb[i];
        if (flag_we[2] && z_chain) nf[2] = m_flags[2] & Z;
        if (alu_valid) m_result = ALU_result;
        m_rvalid = alu_valid;
        if (cond_eval) m_ctrue = cond_ref(m_flags, cond);
        m_cvalid = cond_eval;
        if (push && pop) begin
            if (m_stack.size() == 0) begin
                m_stack.push_back(m_flags);
                if (alu_valid) m_flags = nf;
            end else begin
                m_stack[m_stack.size() - 1] = m_flags;
            end
        end else if (pop) begin
            if (m_stack.size() == 0) m_err = 1'b1;
            else m_flags = m_stack.pop_back();
        end else begin
            if (push) begin
                if (m_stack.size() == DEPTH) m_err = 1'b1;
                else m_stack.push_back(m_flags);
            end
            if (alu_valid) m_flags = nf;
        end
    endtask

    task automatic check_all();
        check_eq("flags",        flags,        m_flags);
        check_eq("C_in",         C_in,         m_flags[1]);
        check_eq("result_q",     result_q,     m_result);
        check_eq("result_valid", result_valid, m_rvalid);
        check_eq("cond_true",    cond_true,    m_ctrue);
        check_eq("cond_valid",   cond_valid,   m_cvalid);
        check_eq("stack_empty",  stack_empty,  m_stack.size() == 0);
        check_eq("stack_full",   stack_full,   m_stack.size() == DEPTH);
        check_eq("stack_err",    stack_err,    m_err);
    endtask

    task automatic idle();
        reset = 0; alu_valid = 0; ALU_result = '0; {S, Z, C, V} = 4'h0; flag_we = 4'h0;
        z_chain = 0; cond_eval = 0; cond = 4'h0; push = 0; pop = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic capture(input logic [WIDTH-1:0] r, input logic [3:0] f,
                           input logic [3:0] we, input logic zc);
        idle();
        alu_valid = 1; ALU_result = r; {S, Z, C, V} = f; flag_we = we; z_chain = zc;
        cycle();
    endtask

    task automatic do_reset();
        idle(); reset = 1; cycle(); idle();
    endtask

    logic [3:0] vals [4];

    initial begin
        vals[0] = 4'hA; vals[1] = 4'h5; vals[2] = 4'hC; vals[3] = 4'h3;
        idle();
        do_reset();
        check_eq("rst_flags", flags, 4'h0);
        check_eq("rst_empty", stack_empty, 1'b1);

        // First capture
        capture(16'h000F, 4'b0010, 4'hF, 1'b0);
        check_eq("cap_result", result_q, 16'h000F);
        check_eq("cap_flags", flags, 4'b0010);
        check_eq("cap_cin", C_in, 1'b1);
        check_eq("cap_rvalid", result_valid, 1'b1);
        idle(); cycle();
        check_eq("rvalid_pulse", result_valid, 1'b0);

        // Masked Z update, then HI / CS
        capture(16'h1234, 4'b1100, 4'b0100, 1'b0);
        check_eq("mask_flags", flags, 4'b0110);
        idle(); cond_eval = 1; cond = 4'd9; cycle();
        check_eq("cond_hi", cond_true, 1'b0);
        check_eq("cond_hi_v", cond_valid, 1'b1);
        idle(); cond_eval = 1; cond = 4'd3; cycle();
        check_eq("cond_cs", cond_true, 1'b1);
        idle(); cycle();
        check_eq("cond_hold", cond_true, 1'b1);
        check_eq("cond_v_pulse", cond_valid, 1'b0);

        // z_chain
        capture(16'h0000, 4'b0100, 4'hF, 1'b0);
        capture(16'h0001, 4'b0000, 4'b0100, 1'b1);
        check_eq("zchain_0", flags[2], 1'b0);
        capture(16'h0000, 4'b0100, 4'hF, 1'b0);
        capture(16'h0000, 4'b0100, 4'b0100, 1'b1);
        check_eq("zchain_1", flags[2], 1'b1);

        // Stack fill, overflow, LIFO drain, underflow
        for (int i = 0; i < 4; i++) begin
            capture(16'h0, vals[i], 4'hF, 1'b0);
            idle(); push = 1; cycle();
        end
        check_eq("stk_full", stack_full, 1'b1);
        idle(); push = 1; cycle();
        check_eq("stk_ovf_err", stack_err, 1'b1);
        check_eq("stk_ovf_full", stack_full, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            idle(); pop = 1; cycle();
            check_eq("stk_pop", flags, vals[i]);
        end
        idle(); pop = 1; cycle();
        check_eq("stk_unf_flags", flags, vals[0]);
        check_eq("stk_unf_empty", stack_empty, 1'b1);

        // Pop wins over simultaneous capture
        do_reset();
        idle(); push = 1; cycle();
        idle(); pop = 1; alu_valid = 1; ALU_result = 16'hABCD; {S, Z, C, V} = 4'hF;
        flag_we = 4'hF; cycle();
        check_eq("popcap_flags", flags, 4'h0);
        check_eq("popcap_result", result_q, 16'hABCD);

        // Reset mid-stack with sticky error
        idle(); pop = 1; cycle();
        capture(16'h5555, 4'h9, 4'hF, 1'b0);
        idle(); push = 1; cycle();
        idle(); push = 1; cond_eval = 1; cond = 4'd0; cycle();
        check_eq("pre_rst_err", stack_err, 1'b1);
        do_reset();
        check_eq("rst2_flags", flags, 4'h0);
        check_eq("rst2_result", result_q, 16'h0);
        check_eq("rst2_ctrue", cond_true, 1'b0);
        check_eq("rst2_empty", stack_empty, 1'b1);
        check_eq("rst2_err", stack_err, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            reset      = ($urandom_range(0, 63) == 0);
            alu_valid  = 1'($urandom_range(0, 1));
            ALU_result = WIDTH'($urandom);
            {S, Z, C, V} = 4'($urandom);
            flag_we    = 4'($urandom);
            z_chain    = 1'($urandom_range(0, 1));
            cond_eval  = 1'($urandom_range(0, 1));
            cond       = 4'($urandom);
            push       = ($urandom_range(0, 9) < 3);
            pop        = ($urandom_range(0, 9) < 2);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
